// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub frame accumulator: FSM state encoding,
// the upstream sample width and default block parameters.
// Optional saturation is selected by the macro ADDSUB_ACCUM_SAT_EN.
package addsub_pkg;

  // Width of the y1/y2 results coming from the add/sub stage
  localparam int DATA_W = 4;

  // Default accumulator width and frame length
  localparam int ACC_W_DEF     = 8;
  localparam int FRAME_LEN_DEF = 4;

  // Frame counter width, wide enough for the largest legal FRAME_LEN (255)
  localparam int CNT_W = 8;

  // ACC: absorbing samples; DONE: presenting the frame total
  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage : addsub_pkg

// File: rtl/addsub_sat_add.sv
// One accumulate step: acc + extended sample with signed overflow detection.
// When ADDSUB_ACCUM_SAT_EN is defined the result clamps to the signed range
// on overflow; otherwise it wraps modulo 2^ACC_W.
module addsub_sat_add #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] sample,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw_sum;

  // Signed add, overflow when both operands share a sign the result lacks
  always_comb begin
    raw_sum = acc + sample;
    ovf     = (acc[ACC_W-1] == sample[ACC_W-1]) &&
              (raw_sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef ADDSUB_ACCUM_SAT_EN
    if (ovf) begin
      // Negative operands overflowed downwards, positive ones upwards
      sum = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                         : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum = raw_sum;
    end
`else
    sum = raw_sum;
`endif
  end

endmodule : addsub_sat_add

// File: rtl/addsub_accum.sv
// Frame accumulator downstream of the 4-bit add/sub stage. Sums FRAME_LEN
// accepted samples (y1 zero-extended or y2 sign-extended, chosen by sel)
// and presents the signed total with a sticky per-frame overflow flag.
// Saturating accumulation is enabled by defining ADDSUB_ACCUM_SAT_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// in_ready/out_valid depend only on registered state, never on in_valid or
// out_ready; once out_valid is high it stays high with stable out_data/ovf
// until out_ready is seen, except for clear or rst_n.
module addsub_accum
  import addsub_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sel,
  input  logic [DATA_W-1:0] y1,
  input  logic [DATA_W-1:0] y2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] step_sum;
  logic             step_ovf;

  // Sum is unsigned 0..15, difference is signed -8..7
  always_comb begin
    if (sel) begin
      sample_ext = {{(ACC_W-DATA_W){y2[DATA_W-1]}}, y2};
    end else begin
      sample_ext = {{(ACC_W-DATA_W){1'b0}}, y1};
    end
  end

  addsub_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc    (acc_q),
    .sample (sample_ext),
    .sum    (step_sum),
    .ovf    (step_ovf)
  );

  // Handshake outputs are pure state decodes
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

  // Next-state logic for FSM, accumulator, counter and output register
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    case (state_q)
      ACC: begin
        if (clear) begin
          // Abort wins over a same-cycle sample, which is dropped
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid) begin
          acc_d = step_sum;
          ovf_d = ovf_q | step_ovf;
          if (cnt_q == LAST_CNT) begin
            cnt_d      = '0;
            out_data_d = step_sum;
            state_d    = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Frame leaves on handshake or abort; out_data keeps the last total
        if (clear || out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule : addsub_accum

// File: doc/addsub_accum.md
# addsub_accum

Frame accumulator that sits directly downstream of the 4-bit add/subtract stage. It consumes one stage result per accepted transfer: either the sum or the difference, chosen per transfer. It adds FRAME_LEN consecutive results into a signed accumulator and presents the frame total on a valid/ready output, with an overflow flag. It turns the combinational add/sub stage into a streaming reduction unit.

## Interface
- ACC_W, default 8: accumulator and output width, signed two's complement; legal range 5..16.
- FRAME_LEN, default 4: accepted samples per frame; legal range 1..255.
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset. Asynchronous and active-low; it is the only reset.
- clear, input, 1: synchronous frame abort. Zeroes the accumulator, count and ovf.
- in_valid, input, 1: upstream sample valid.
- in_ready, output, 1: block can accept a sample.
- sel, input, 1: selects the sample source. 0 takes y1 (the sum) zero-extended. 1 takes y2 (the difference) sign-extended.
- y1, input, 4: sum result from the add/sub stage.
- y2, input, 4: difference result from the add/sub stage.
- out_valid, output, 1: frame total valid.
- out_ready, input, 1: downstream accepts the frame total.
- out_data, output, ACC_W: frame total, signed.
- ovf, output, 1: at least one signed overflow occurred in this frame.

## Operation
- The FSM has two states, ACC and DONE. Reset enters ACC.
- **ACC state**
  - in_ready=1 and out_valid=0.
  - An accept is in_valid && in_ready. On accept: acc <= acc + ext(sample) and cnt <= cnt+1.
  - The accept that makes cnt reach FRAME_LEN moves the FSM to DONE. In the same edge, out_data loads the final sum and cnt returns to 0.
- **DONE state**
  - in_ready=0 and out_valid=1. in_valid is ignored.
  - out_data and ovf hold steady until out_ready=1.
  - On out_ready=1, the FSM returns to ACC, acc clears to 0 and ovf clears to 0.
- **Sample extension**
  - sel=0: the y1 value 0..15 is zero-extended to ACC_W.
  - sel=1: y2 is treated as signed -8..7 and sign-extended.
- **Overflow**
  - Overflow is signed: both operands have the same sign and the result sign differs.
  - ovf is sticky for the current frame.
- **clear**
  - In ACC, clear has priority over an accept in the same cycle. The sample is discarded, and acc, cnt and ovf become 0.
  - In DONE, clear drops out_valid and returns the FSM to ACC.
- **rst_n mid-operation:** all state returns immediately to reset values, whatever the FSM state.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, ovf=0. Internally, acc=0, cnt=0, state=ACC.
- Throughput in ACC is one sample per cycle.
- Latency: out_valid rises the cycle after the FRAME_LEN-th accept.
- Minimum frame period is FRAME_LEN+1 cycles. This includes one DONE cycle when out_ready is held high.
- in_ready is a registered-state decode only; it has no combinational path from in_valid.
- out_valid never drops without an out_ready handshake. The exceptions are clear and rst_n.
- Upstream y1, y2 and sel are sampled only on an accept edge.

## Configuration
- Macro ADDSUB_ACCUM_SAT_EN.
- When defined, each accumulate step saturates: positive overflow gives 2^(ACC_W-1)-1 and negative overflow gives -2^(ACC_W-1). ovf still sets.
- When undefined, the sum wraps modulo 2^ACC_W and ovf sets.

## Structure
- Package addsub_pkg holds:
  - the state encodings ACC=1'b0 and DONE=1'b1;
  - localparams for the data width (4) and the default ACC_W and FRAME_LEN.
- One sub-module, addsub_sat_add, parameterised by ACC_W.
  - Inputs: acc and the extended sample.
  - Outputs: the next sum and an overflow bit.
  - Saturation is compiled in by ADDSUB_ACCUM_SAT_EN.
- The FSM, counter and output register stay in addsub_accum.

## Test plan
- **Basic frame** (ACC_W=8, FRAME_LEN=4, sel=0): y1 = 3, 5, 7, 1 on consecutive cycles → one cycle after the 4th accept, out_valid=1, out_data=8'h10, ovf=0.
- **Signed difference:** sel=0 y1 = 2, then sel=1 y2 = 4'hF three times (-1 each) → out_data=8'hFF (-1), ovf=0.
- **Backpressure:** after frame completion, hold out_ready=0 for 5 cycles while in_valid=1 → out_data held, in_ready=0, no sample absorbed. Then raise out_ready → next cycle in_ready=1 and a new frame starts from 0.
- **Overflow** (ACC_W=6, sel=0): y1 = 15 four times.
  - Without the macro → out_data=6'h3C, ovf=1.
  - With the macro → out_data=6'h1F, ovf=1.
- **clear with accept:** after two accepts of y1=4, assert clear together with in_valid carrying y1=9, then accept 1, 1, 1, 1 → out_data=8'h04 and the 9 is discarded.
- **Reset mid-frame:** pull rst_n low asynchronously after two accepts → immediately in_ready=1, out_valid=0, out_data=0, ovf=0. After release, a fresh 4-sample frame of y1 = 1, 1, 1, 1 gives 8'h04.
